// File: rtl/multicycle_sequencer_pkg.sv
// Shared opcode, ALU-code and state definitions for the multi-cycle sequencer.
package multicycle_sequencer_pkg;

   // Instruction opcodes
   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_LDA_IMM = 8'h01;
   localparam logic [7:0] OP_LDX_IMM = 8'h02;
   localparam logic [7:0] OP_LDY_IMM = 8'h03;
   localparam logic [7:0] OP_LDA_ABS = 8'h04;
   localparam logic [7:0] OP_STA_ABS = 8'h05;
   localparam logic [7:0] OP_ADD_IMM = 8'h10;
   localparam logic [7:0] OP_SUB_IMM = 8'h11;
   localparam logic [7:0] OP_AND_IMM = 8'h12;
   localparam logic [7:0] OP_OR_IMM  = 8'h13;
   localparam logic [7:0] OP_XOR_IMM = 8'h14;
   localparam logic [7:0] OP_INC     = 8'h18;
   localparam logic [7:0] OP_DEC     = 8'h19;
   localparam logic [7:0] OP_NOT     = 8'h1A;
   localparam logic [7:0] OP_BEQ     = 8'h20;
   localparam logic [7:0] OP_BNE     = 8'h21;
   localparam logic [7:0] OP_BRA     = 8'h22;
   localparam logic [7:0] OP_JMP_ABS = 8'h23;
   localparam logic [7:0] OP_RTI     = 8'h30;
   localparam logic [7:0] OP_HLT     = 8'hFF;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd4;
   localparam logic [3:0] ALU_OR     = 4'd5;
   localparam logic [3:0] ALU_XOR    = 4'd6;
   localparam logic [3:0] ALU_NOT    = 4'd7;
   localparam logic [3:0] ALU_INC    = 4'd12;
   localparam logic [3:0] ALU_DEC    = 4'd13;
   localparam logic [3:0] ALU_PASS_B = 4'd14;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_OPND_LO, ST_OPND_HI,
      ST_LOAD, ST_STORE, ST_EXEC, ST_HALT
   } state_t;

   // Operand-fetch class of an opcode
   typedef enum logic [1:0] {CLS_IMPL, CLS_IMM, CLS_REL, CLS_ABS} op_class_t;

   // Register written when the instruction retires
   typedef enum logic [1:0] {DST_NONE, DST_ACC, DST_X, DST_Y} dest_t;

endpackage

// File: rtl/multicycle_sequencer_opcode_classifier.sv
// Combinational opcode decode: operand class, ALU op, destination, flag write.
module opcode_classifier
   import multicycle_sequencer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] opcode,
   output op_class_t         op_class,
   output logic [3:0]        alu_op,
   output dest_t             dest,
   output logic              flags_wr,
   output logic              legal
);

   // Unknown opcodes fall out as implied, no writes, legal=0 (run as NOP)
   always_comb begin
      op_class = CLS_IMPL;
      alu_op   = ALU_ADD;
      dest     = DST_NONE;
      flags_wr = 1'b0;
      legal    = 1'b1;
      case (opcode)
         DATA_W'(OP_NOP), DATA_W'(OP_RTI), DATA_W'(OP_HLT): ;
         DATA_W'(OP_LDA_IMM): begin op_class = CLS_IMM; alu_op = ALU_PASS_B; dest = DST_ACC; end
         DATA_W'(OP_LDX_IMM): begin op_class = CLS_IMM; alu_op = ALU_PASS_B; dest = DST_X; end
         DATA_W'(OP_LDY_IMM): begin op_class = CLS_IMM; alu_op = ALU_PASS_B; dest = DST_Y; end
         DATA_W'(OP_LDA_ABS): begin op_class = CLS_ABS; alu_op = ALU_PASS_B; dest = DST_ACC; end
         DATA_W'(OP_STA_ABS), DATA_W'(OP_JMP_ABS): op_class = CLS_ABS;
         DATA_W'(OP_ADD_IMM): begin op_class = CLS_IMM; alu_op = ALU_ADD; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_SUB_IMM): begin op_class = CLS_IMM; alu_op = ALU_SUB; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_AND_IMM): begin op_class = CLS_IMM; alu_op = ALU_AND; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_OR_IMM):  begin op_class = CLS_IMM; alu_op = ALU_OR;  dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_XOR_IMM): begin op_class = CLS_IMM; alu_op = ALU_XOR; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_INC):     begin alu_op = ALU_INC; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_DEC):     begin alu_op = ALU_DEC; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_NOT):     begin alu_op = ALU_NOT; dest = DST_ACC; flags_wr = 1'b1; end
         DATA_W'(OP_BEQ), DATA_W'(OP_BNE), DATA_W'(OP_BRA): op_class = CLS_REL;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, walks fetch/operand/data/exec
// over a ready-handshaked memory port, handles branches, interrupts and halt.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int              DATA_W     = 8,
   parameter int              ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
   parameter logic [ADDR_W-1:0] IRQ_VECTOR = 16'hFF00,
   parameter int              Z_BIT      = 1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] acc_in,
   input  logic [7:0]        flags_in,
   input  logic              irq,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] operand,
   output logic              acc_write,
   output logic              x_write,
   output logic              y_write,
   output logic              flags_write,
   output logic [ADDR_W-1:0] pc,
   output logic              irq_ack,
   output logic              halted,
   output logic              illegal,
   output logic              done
);

   state_t            state;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] epc;
   logic              ie;
   logic              irq_cyc;   // current EXEC cycle is the interrupt-entry cycle

   logic [DATA_W-1:0] cls_in;
   op_class_t         c_class;
   logic [3:0]        c_alu;
   dest_t             c_dest;
   logic              c_flags;
   logic              c_legal;

   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] exec_pc;
   logic [ADDR_W-1:0] ret_pc;
   logic              ie_eff;
   logic              to_exec;
   logic              irq_take;

   // Only the zero flag steers branches; the rest pass through to other users
   logic unused_flags;
   assign unused_flags = ^flags_in;

   // During FETCH the opcode is still on the bus; afterwards it lives in ir
   assign cls_in = (state == ST_FETCH) ? mem_rdata : ir;

   opcode_classifier #(.DATA_W(DATA_W)) u_cls (
      .opcode   (cls_in),
      .op_class (c_class),
      .alu_op   (c_alu),
      .dest     (c_dest),
      .flags_wr (c_flags),
      .legal    (c_legal)
   );

   // Memory side is decoded from state alone so it holds through wait states
   assign mem_req   = state inside {ST_FETCH, ST_OPND_LO, ST_OPND_HI, ST_LOAD, ST_STORE};
   assign mem_we    = (state == ST_STORE);
   assign mem_addr  = (state inside {ST_LOAD, ST_STORE}) ? addr_r : pc;
   assign mem_wdata = acc_in;

   assign br_target = pc + {{(ADDR_W-DATA_W){operand[DATA_W-1]}}, operand};

   // PC / interrupt-enable outcome of the instruction sitting in EXEC
   always_comb begin
      exec_pc = pc;
      ie_eff  = ie;
      case (ir)
         DATA_W'(OP_BEQ):     if (flags_in[Z_BIT])  exec_pc = br_target;
         DATA_W'(OP_BNE):     if (!flags_in[Z_BIT]) exec_pc = br_target;
         DATA_W'(OP_BRA):     exec_pc = br_target;
         DATA_W'(OP_JMP_ABS): exec_pc = addr_r;
         DATA_W'(OP_RTI):     begin exec_pc = epc; ie_eff = 1'b1; end
         default: ;
      endcase
   end

   // Completing transfer that leads straight into EXEC, and interrupt sampling
   always_comb begin
      to_exec = 1'b0;
      case (state)
         ST_FETCH:         to_exec = mem_ready && (c_class == CLS_IMPL);
         ST_OPND_LO:       to_exec = mem_ready && (c_class != CLS_ABS);
         ST_OPND_HI:       to_exec = mem_ready && (ir == DATA_W'(OP_JMP_ABS));
         ST_LOAD, ST_STORE: to_exec = mem_ready;
         default: ;
      endcase
      irq_take = 1'b0;
      ret_pc   = pc;
      case (state)
         ST_IDLE, ST_HALT: irq_take = irq && ie;
         ST_EXEC: begin
            irq_take = irq && ie_eff && !irq_cyc && (ir != DATA_W'(OP_HLT));
            ret_pc   = exec_pc;
         end
         default: ;
      endcase
   end

   // Sequencer FSM with registered strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         epc         <= RESET_PC;
         ie          <= 1'b1;
         ir          <= '0;
         addr_r      <= '0;
         irq_cyc     <= 1'b0;
         alu_op      <= '0;
         operand     <= '0;
         acc_write   <= 1'b0;
         x_write     <= 1'b0;
         y_write     <= 1'b0;
         flags_write <= 1'b0;
         irq_ack     <= 1'b0;
         halted      <= 1'b0;
         illegal     <= 1'b0;
         done        <= 1'b0;
      end else begin
         acc_write   <= 1'b0;
         x_write     <= 1'b0;
         y_write     <= 1'b0;
         flags_write <= 1'b0;
         irq_ack     <= 1'b0;
         illegal     <= 1'b0;
         done        <= 1'b0;
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: if (mem_ready) begin
               ir <= mem_rdata;
               pc <= pc + ADDR_W'(1);
               state <= ST_OPND_LO;
            end
            ST_OPND_LO: if (mem_ready) begin
               operand <= mem_rdata;
               addr_r  <= {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
               pc      <= pc + ADDR_W'(1);
               state   <= ST_OPND_HI;
            end
            ST_OPND_HI: if (mem_ready) begin
               addr_r[ADDR_W-1:DATA_W] <= mem_rdata[ADDR_W-DATA_W-1:0];
               pc    <= pc + ADDR_W'(1);
               state <= (ir == DATA_W'(OP_LDA_ABS)) ? ST_LOAD : ST_STORE;
            end
            ST_LOAD: if (mem_ready) operand <= mem_rdata;
            ST_STORE: ;
            ST_EXEC: begin
               if (irq_cyc) begin
                  irq_cyc <= 1'b0;
                  state   <= ST_FETCH;
               end else begin
                  pc <= exec_pc;
                  ie <= ie_eff;
                  if (ir == DATA_W'(OP_HLT)) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: ;
            default: state <= ST_IDLE;
         endcase
         // Entering EXEC: raise this instruction's strobes for exactly one cycle
         if (to_exec) begin
            state       <= ST_EXEC;
            done        <= 1'b1;
            acc_write   <= (c_dest == DST_ACC);
            x_write     <= (c_dest == DST_X);
            y_write     <= (c_dest == DST_Y);
            flags_write <= c_flags;
            illegal     <= !c_legal;
            if (c_dest != DST_NONE || c_flags) alu_op <= c_alu;
         end
         // Interrupt entry at an instruction boundary replaces the next fetch
         if (irq_take) begin
            state   <= ST_EXEC;
            irq_cyc <= 1'b1;
            irq_ack <= 1'b1;
            epc     <= ret_pc;
            pc      <= IRQ_VECTOR;
            ie      <= 1'b0;
            halted  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scenario bench for multicycle_sequencer: byte-array memory, retire/store scoreboards.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ready;
   logic [15:0] mem_addr, pc;
   logic [7:0]  mem_wdata, mem_rdata, acc_in, flags_in, operand;
   logic        irq, acc_write, x_write, y_write, flags_write, irq_ack, halted, illegal, done;
   logic [3:0]  alu_op;

   logic [7:0]  tb_mem [0:65535];
   logic [7:0]  prog [$];

   typedef struct {
      logic [15:0] pc;
      logic aw, xw, yw, fw, ill, chk_op;
      logic [3:0]  alu;
      logic [7:0]  opnd;
   } ret_t;
   typedef struct { logic [15:0] addr; logic [7:0] data; } st_t;
   ret_t ret_q [$];
   st_t  st_q [$];
   int n_cmp = 0, n_err = 0, wr_cnt = 0;

   always #5 clk = ~clk;
   assign mem_rdata = tb_mem[mem_addr];

   multicycle_sequencer dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .acc_in(acc_in),
      .flags_in(flags_in), .irq(irq), .alu_op(alu_op), .operand(operand),
      .acc_write(acc_write), .x_write(x_write), .y_write(y_write), .flags_write(flags_write),
      .pc(pc), .irq_ack(irq_ack), .halted(halted), .illegal(illegal), .done(done)
   );

   task push_ret(input logic [15:0] p, input logic aw, xw, yw, fw, input logic [3:0] alu,
                 input logic chk_op, input logic [7:0] opnd, input logic ill);
      ret_t r;
      r.pc = p; r.aw = aw; r.xw = xw; r.yw = yw; r.fw = fw; r.alu = alu;
      r.chk_op = chk_op; r.opnd = opnd; r.ill = ill;
      ret_q.push_back(r);
   endtask

   task load_prog(input logic [15:0] a);
      foreach (prog[i]) tb_mem[a + 16'(i)] = prog[i];
   endtask

   // Retire and store scoreboard, sampled on the falling edge
   task monitor;
      ret_t r;
      st_t  s;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (done) begin
               n_cmp++;
               if (ret_q.size() == 0) begin
                  n_err++; $display("FAIL retire_unexpected pc=%h", pc);
               end else begin
                  r = ret_q.pop_front();
                  if ({pc, acc_write, x_write, y_write, flags_write, illegal} !==
                      {r.pc, r.aw, r.xw, r.yw, r.fw, r.ill}) begin
                     n_err++;
                     $display("FAIL retire got pc=%h a/x/y/f/ill=%b%b%b%b%b exp pc=%h %b%b%b%b%b",
                              pc, acc_write, x_write, y_write, flags_write, illegal,
                              r.pc, r.aw, r.xw, r.yw, r.fw, r.ill);
                  end
                  if ((r.aw | r.xw | r.yw | r.fw) && alu_op !== r.alu) begin
                     n_err++; $display("FAIL retire_alu got=%0d exp=%0d", alu_op, r.alu);
                  end
                  if (r.chk_op && operand !== r.opnd) begin
                     n_err++; $display("FAIL retire_operand got=%h exp=%h", operand, r.opnd);
                  end
               end
            end else begin
               n_cmp++;
               if ({acc_write, x_write, y_write, flags_write, illegal} !== 5'b0) begin
                  n_err++; $display("FAIL strobe_without_done got=%b exp=00000",
                                    {acc_write, x_write, y_write, flags_write, illegal});
               end
            end
            if (mem_req && mem_we && mem_ready) begin
               wr_cnt++;
               n_cmp++;
               if (st_q.size() == 0) begin
                  n_err++; $display("FAIL store_unexpected addr=%h data=%h", mem_addr, mem_wdata);
               end else begin
                  s = st_q.pop_front();
                  if ({mem_addr, mem_wdata} !== {s.addr, s.data}) begin
                     n_err++;
                     $display("FAIL store got=%h/%h exp=%h/%h", mem_addr, mem_wdata, s.addr, s.data);
                  end
               end
            end
         end
      end
   endtask

   task hold_reset;
      reset = 1'b1; irq = 1'b0; mem_ready = 1'b1; flags_in = 8'h00; acc_in = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
      ret_q.delete(); st_q.delete(); wr_cnt = 0;
   endtask

   task wait_done(input int bound, output int cyc);
      cyc = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         if (done) begin cyc = i; break; end
      end
   endtask

   task wait_halt(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (halted) begin ok = 1'b1; break; end
      end
   endtask

   task test_reset;
      hold_reset();
      n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL rst_pc got=%h exp=0000", pc); end
      n_cmp++; if ({mem_req, mem_we} !== 2'b00) begin n_err++; $display("FAIL rst_mem got=%b exp=00", {mem_req, mem_we}); end
      n_cmp++; if ({acc_write, x_write, y_write, flags_write, done} !== 5'b0) begin
         n_err++; $display("FAIL rst_strobes got=%b exp=00000", {acc_write, x_write, y_write, flags_write, done}); end
      n_cmp++; if ({alu_op, operand} !== 12'h000) begin n_err++; $display("FAIL rst_alu_opnd got=%h exp=000", {alu_op, operand}); end
      n_cmp++; if ({halted, illegal, irq_ack} !== 3'b000) begin n_err++; $display("FAIL rst_status got=%b exp=000", {halted, illegal, irq_ack}); end
   endtask

   task test_fetch_imm;
      bit ok;
      hold_reset();
      prog = '{8'h01, 8'h2A, 8'h02, 8'h3B, 8'h03, 8'h4C, 8'h11, 8'h01, 8'hFF}; load_prog(16'h0000);
      push_ret(16'h0002, 1, 0, 0, 0, 4'd14, 1, 8'h2A, 0);
      push_ret(16'h0004, 0, 1, 0, 0, 4'd14, 1, 8'h3B, 0);
      push_ret(16'h0006, 0, 0, 1, 0, 4'd14, 1, 8'h4C, 0);
      push_ret(16'h0008, 1, 0, 0, 1, 4'd1,  1, 8'h01, 0);
      push_ret(16'h0009, 0, 0, 0, 0, 4'd0,  0, 8'h00, 0);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL fetch0 got=%b/%h exp=1/0000", mem_req, mem_addr); end
      @(negedge clk);
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h0001}) begin n_err++; $display("FAIL opnd1 got=%b/%h exp=1/0001", mem_req, mem_addr); end
      @(negedge clk);
      n_cmp++; if ({done, acc_write, alu_op, operand, pc} !== {1'b1, 1'b1, 4'd14, 8'h2A, 16'h0002}) begin
         n_err++; $display("FAIL lda_imm_exec got=%b%b/%0d/%h/%h exp=11/14/2a/0002", done, acc_write, alu_op, operand, pc); end
      wait_halt(40, ok);
      n_cmp++; if (!ok || mem_req !== 1'b0) begin n_err++; $display("FAIL imm_halt got=%b/%b exp=1/0", ok, mem_req); end
      n_cmp++; if (ret_q.size() != 0) begin n_err++; $display("FAIL imm_pending got=%0d exp=0", ret_q.size()); end
   endtask

   task test_wait_state;
      bit ok;
      hold_reset();
      prog = '{8'h18, 8'hFF}; load_prog(16'h0000);
      push_ret(16'h0001, 1, 0, 0, 1, 4'd12, 1, 8'h00, 0);
      push_ret(16'h0002, 0, 0, 0, 0, 4'd0,  0, 8'h00, 0);
      mem_ready = 1'b0;
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({mem_req, mem_addr, pc, done, acc_write} !== {1'b1, 16'h0000, 16'h0000, 2'b00}) begin
            n_err++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h/%b exp=1/0000/0000/0", i, mem_req, mem_addr, pc, done); end
         if (i == 4) mem_ready = 1'b1;
      end
      @(negedge clk);
      n_cmp++; if ({done, acc_write, flags_write, pc} !== {3'b111, 16'h0001}) begin
         n_err++; $display("FAIL late_retire got=%b%b%b/%h exp=111/0001", done, acc_write, flags_write, pc); end
      wait_halt(20, ok);
      n_cmp++; if (!ok || ret_q.size() != 0) begin n_err++; $display("FAIL wait_end got=%b/%0d exp=1/0", ok, ret_q.size()); end
   endtask

   task test_branch(input logic z);
      int cyc;
      bit ok;
      hold_reset();
      prog = '{8'h23, 8'h10, 8'h00}; load_prog(16'h0000);
      prog = '{8'h20, 8'hFC};        load_prog(16'h0010);
      prog = '{8'hFF};               load_prog(16'h000E); load_prog(16'h0012);
      flags_in = z ? 8'h02 : 8'h00;
      push_ret(16'h0003, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      push_ret(16'h0012, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      push_ret(z ? 16'h000F : 16'h0013, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      reset = 1'b0;
      wait_done(10, cyc);
      n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL jmp_cycles got=%0d exp=4", cyc); end
      @(negedge clk);
      n_cmp++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL jmp_target got=%h exp=0010", mem_addr); end
      wait_done(10, cyc);
      @(negedge clk);
      n_cmp++; if (pc !== (z ? 16'h000E : 16'h0012)) begin
         n_err++; $display("FAIL beq_z%0d got=%h exp=%h", z, pc, z ? 16'h000E : 16'h0012); end
      wait_halt(20, ok);
      n_cmp++; if (!ok || ret_q.size() != 0) begin n_err++; $display("FAIL branch_end got=%b/%0d exp=1/0", ok, ret_q.size()); end
   endtask

   task test_store_load;
      int cyc;
      bit ok;
      st_t s;
      hold_reset();
      prog = '{8'h05, 8'h34, 8'h12, 8'h04, 8'h34, 8'h12, 8'hFF}; load_prog(16'h0000);
      tb_mem[16'h1234] = 8'h5A;
      acc_in = 8'h77;
      s.addr = 16'h1234; s.data = 8'h77; st_q.push_back(s);
      push_ret(16'h0003, 0, 0, 0, 0, 4'd0,  0, 8'h00, 0);
      push_ret(16'h0006, 1, 0, 0, 0, 4'd14, 1, 8'h5A, 0);
      push_ret(16'h0007, 0, 0, 0, 0, 4'd0,  0, 8'h00, 0);
      reset = 1'b0;
      wait_done(12, cyc);
      n_cmp++; if (cyc != 5 || pc !== 16'h0003) begin n_err++; $display("FAIL sta_timing got=%0d/%h exp=5/0003", cyc, pc); end
      wait_done(12, cyc);
      n_cmp++; if (cyc != 5) begin n_err++; $display("FAIL lda_abs_cycles got=%0d exp=5", cyc); end
      wait_halt(20, ok);
      n_cmp++; if (!ok || wr_cnt != 1 || st_q.size() != 0) begin
         n_err++; $display("FAIL store_count got=%b/%0d/%0d exp=1/1/0", ok, wr_cnt, st_q.size()); end
   endtask

   task test_irq;
      bit ok;
      hold_reset();
      prog = '{8'h10, 8'h05, 8'hFF, 8'hFF}; load_prog(16'h0000);
      prog = '{8'h30};                      load_prog(16'hFF00);
      push_ret(16'h0002, 1, 0, 0, 1, 4'd0, 1, 8'h05, 0);
      push_ret(16'hFF01, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      push_ret(16'h0003, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      push_ret(16'hFF01, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      push_ret(16'h0004, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk); irq = 1'b1;
      @(negedge clk);
      n_cmp++; if ({done, irq_ack} !== 2'b10) begin n_err++; $display("FAIL add_retire got=%b exp=10", {done, irq_ack}); end
      @(negedge clk);
      n_cmp++; if ({irq_ack, done, pc} !== {2'b10, 16'hFF00}) begin
         n_err++; $display("FAIL irq_entry got=%b%b/%h exp=10/ff00", irq_ack, done, pc); end
      irq = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if ({mem_addr, pc} !== {16'h0002, 16'h0002}) begin
         n_err++; $display("FAIL rti_return got=%h/%h exp=0002/0002", mem_addr, pc); end
      wait_halt(10, ok);
      irq = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (irq_ack) begin ok = 1'b1; break; end
      end
      n_cmp++; if (!ok || pc !== 16'hFF00 || halted !== 1'b0) begin
         n_err++; $display("FAIL wake_ack got=%b/%h/%b exp=1/ff00/0", ok, pc, halted); end
      irq = 1'b0;
      wait_halt(20, ok);
      n_cmp++; if (!ok || pc !== 16'h0004 || ret_q.size() != 0) begin
         n_err++; $display("FAIL irq_end got=%b/%h/%0d exp=1/0004/0", ok, pc, ret_q.size()); end
   endtask

   task test_halt_reset;
      int cyc;
      bit ok;
      hold_reset();
      prog = '{8'h77, 8'hFF}; load_prog(16'h0000);
      push_ret(16'h0001, 0, 0, 0, 0, 4'd0, 0, 8'h00, 1);
      push_ret(16'h0002, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      reset = 1'b0;
      wait_done(5, cyc);
      n_cmp++; if (cyc != 2 || illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse got=%0d/%b exp=2/1", cyc, illegal); end
      wait_halt(10, ok);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if ({ok, halted, mem_req} !== 3'b110) begin n_err++; $display("FAIL halt_idle got=%b exp=110", {ok, halted, mem_req}); end
      end
      irq = 1'b1; mem_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (irq_ack) begin ok = 1'b1; break; end
      end
      irq = 1'b0;
      @(negedge clk);
      n_cmp++; if ({ok, mem_req, mem_addr} !== {2'b11, 16'hFF00}) begin
         n_err++; $display("FAIL stalled_vector_fetch got=%b%b/%h exp=11/ff00", ok, mem_req, mem_addr); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({pc, mem_req, halted, irq_ack, done} !== {16'h0000, 4'b0000}) begin
         n_err++; $display("FAIL reset_mid_fetch got=%h/%b exp=0000/0000", pc, {mem_req, halted, irq_ack, done}); end
      push_ret(16'h0001, 0, 0, 0, 0, 4'd0, 0, 8'h00, 1);
      push_ret(16'h0002, 0, 0, 0, 0, 4'd0, 0, 8'h00, 0);
      mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
         n_err++; $display("FAIL first_fetch_after_reset got=%b/%h exp=1/0000", mem_req, mem_addr); end
      wait_halt(10, ok);
      n_cmp++; if (!ok || ret_q.size() != 0) begin n_err++; $display("FAIL halt_end got=%b/%0d exp=1/0", ok, ret_q.size()); end
   endtask

   initial begin
      irq = 1'b0; mem_ready = 1'b1; flags_in = 8'h00; acc_in = 8'h00;
      fork monitor(); join_none
      test_reset();
      test_fetch_imm();
      test_wait_state();
      test_branch(1'b1);
      test_branch(1'b0);
      test_store_load();
      test_irq();
      test_halt_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "bench timed out");
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Parametrised next-generation instruction sequencer for the 8-bit CPU. It owns the program counter and runs a multi-cycle fetch/operand/data/execute flow over a variable-latency memory handshake. Over the current control unit it adds:
- absolute addressing (load/store)
- signed relative branches and absolute jump
- maskable interrupt entry/return
- halt state and illegal-opcode reporting
It sits between the memory interface and the ALU/register-file datapath.

Parameters:
DATA_W, 8, data/opcode/operand width
ADDR_W, 16, address width; must satisfy DATA_W < ADDR_W <= 2*DATA_W
RESET_PC, 16'h0000, PC value after reset
IRQ_VECTOR, 16'hFF00, PC loaded on interrupt entry
Z_BIT, 1, index of the zero flag within flags_in

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory transaction request
mem_we  out  1  write enable, valid while mem_req is high
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  store data; equals acc_in during STORE
mem_rdata  in  DATA_W  read data, valid when mem_ready is high
mem_ready  in  1  transfer completes on a cycle where mem_req && mem_ready
acc_in  in  DATA_W  accumulator value for stores
flags_in  in  8  datapath flags
irq  in  1  level interrupt request
alu_op  out  4  ALU operation code
operand  out  DATA_W  immediate or loaded byte for the datapath
acc_write / x_write / y_write / flags_write  out  1 each  one-cycle write strobes
pc  out  ADDR_W  program counter
irq_ack  out  1  one-cycle pulse on interrupt entry
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on an unknown opcode
done  out  1  one-cycle pulse when an instruction retires

Behaviour:
States: IDLE, FETCH, OPND_LO, OPND_HI, LOAD, STORE, EXEC, HALT.

- mem_req, mem_we and mem_addr are decoded from the state register only (Moore outputs), so address and request stay stable through wait states.
- mem_req is high in FETCH, OPND_LO, OPND_HI, LOAD and STORE.
  - mem_addr is pc in FETCH/OPND states and the operand address in LOAD/STORE.
  - mem_we is high only in STORE.
- Reset values:
  - state=IDLE, pc=RESET_PC, epc=RESET_PC, ie=1
  - every strobe, alu_op, operand, ir, halted and illegal = 0
  - Reset mid-transaction abandons the transaction immediately.
- IDLE -> FETCH unconditionally.
- A state holds with no register change while mem_ready is low.
- FETCH completion:
  - ir <= mem_rdata, pc <= pc+1.
  - Next state by opcode class: implied -> EXEC; immediate/relative -> OPND_LO; absolute -> OPND_LO then OPND_HI.
- Absolute address:
  - OPND_LO provides the low byte, OPND_HI the high byte (little-endian); each completion increments pc.
  - The address is {hi,lo} truncated to ADDR_W.
- LDA_ABS: OPND_HI -> LOAD, which captures the byte -> EXEC.
- STA_ABS: OPND_HI -> STORE -> EXEC.
- EXEC lasts one cycle and asserts the strobes and done; then HALT for HLT, otherwise FETCH.
  - Loads use alu_op=PASS_B with operand=byte and pulse the matching register write.
  - ALU-immediate ops (ADD/SUB/AND/OR/XOR) and INC/DEC/NOT pulse acc_write and flags_write.
- Branches:
  - target = pc (after the offset byte) + sign-extended 8-bit offset, modulo 2^ADDR_W.
  - BEQ is taken when flags_in[Z_BIT]=1; BNE when it is 0; BRA always.
  - The PC is updated in EXEC.
- JMP_ABS: pc <= operand address in EXEC.
- Interrupts:
  - Sampled only at FETCH entry (instruction boundary) when irq && ie.
  - One EXEC-like cycle: epc <= pc, pc <= IRQ_VECTOR, ie <= 0, irq_ack=1.
  - RTI: pc <= epc, ie <= 1.
  - irq in HALT wakes the block (if ie) via the same entry.
- HLT: halted=1 until reset or interrupt entry.
- Unknown opcode: executes as NOP with illegal=1 in EXEC.
- Zero-wait cycle counts: implied 2, immediate/branch 3, JMP 4, LDA/STA_ABS 5.

Decomposition:
- Shared package holds:
  - Opcodes: NOP 00, LDA_IMM 01, LDX_IMM 02, LDY_IMM 03, LDA_ABS 04, STA_ABS 05, ADD_IMM 10, SUB_IMM 11, AND_IMM 12, OR_IMM 13, XOR_IMM 14, INC 18, DEC 19, NOT 1A, BEQ 20, BNE 21, BRA 22, JMP_ABS 23, RTI 30, HLT FF.
  - ALU codes: ADD 0, SUB 1, AND 4, OR 5, XOR 6, NOT 7, INC 12, DEC 13, PASS_B 14.
  - State encodings.
- One sub-module, opcode_classifier: combinational; maps an opcode to class (implied/imm/rel/abs), alu_op and destination register.

Test Plan:
1. Reset release, zero-wait memory 01 2A -> fetches at 0000 and 0001; cycle 4 after release: acc_write=1, alu_op=14, operand=2A, done=1; pc=0002.
2. mem_ready low for 3 cycles in FETCH -> mem_req=1 and mem_addr=pc held stable, no pc change, no strobes; instruction retires 3 cycles late.
3. At 0x0010, 20 FC: with Z=1 -> pc=000E after EXEC; with Z=0 -> pc=0012.
4. 05 34 12 with acc_in=77 -> exactly one write: mem_addr=1234, mem_we=1, mem_wdata=77; pc=0003; 5 cycles.
5. irq raised during ADD_IMM -> ADD retires; next cycle irq_ack=1, epc=next pc, pc=FF00; RTI at FF00 returns to epc and re-enables interrupts.
6. HLT -> halted=1, no mem_req; then reset asserted mid-fetch with mem_ready low -> reset values; first fetch after release at RESET_PC.
